// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for the RV32I 5-stage core: load-use, jump and bus-wait handling.
// Optional PIPE_CTRL_PERF_EN builds the stall/flush performance counters.
module pipe_ctrl #(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_reg_wen,
    input  logic        ex_jump_en,
    input  logic [31:0] ex_jump_addr,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_hold,
    output logic        if_id_hold,
    output logic        id_ex_hold,
    output logic        ex_mem_hold,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        bus_err_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             bus_wait;
    logic             load_use;
    logic             dispatch;
    logic             take_jump;

    assign bus_wait = mem_req & ~mem_ready;

    assign load_use = ex_is_load & ex_reg_wen & (ex_rd_addr != 5'd0) &
                      ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) |
                       (id_rs2_used & (id_rs2_addr == ex_rd_addr)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // dispatch marks a cycle where the pipeline may advance normally, so jump and
    // load-use are evaluated; this includes the cycle a bus wait is released.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        dispatch      = 1'b0;
        take_jump     = 1'b0;
        pc_hold       = 1'b0;
        if_id_hold    = 1'b0;
        id_ex_hold    = 1'b0;
        ex_mem_hold   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        bus_err_o     = 1'b0;

        case (state)
            RUN: begin
                if (bus_wait) begin
                    pc_hold       = 1'b1;
                    if_id_hold    = 1'b1;
                    id_ex_hold    = 1'b1;
                    ex_mem_hold   = 1'b1;
                    state_next    = WAIT;
                    wait_cnt_next = CNT_W'(1);
                end else begin
                    dispatch = 1'b1;
                end
            end
            WAIT: begin
                if (bus_wait) begin
                    if (wait_cnt == CNT_W'(WAIT_MAX)) begin
                        bus_err_o     = 1'b1;
                        state_next    = RUN;
                        wait_cnt_next = '0;
                    end else begin
                        pc_hold       = 1'b1;
                        if_id_hold    = 1'b1;
                        id_ex_hold    = 1'b1;
                        ex_mem_hold   = 1'b1;
                        wait_cnt_next = wait_cnt + 1'b1;
                    end
                end else begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                    dispatch      = 1'b1;
                end
            end
            FLUSH: begin
                // The PC loads the redirect target here; a jump seen now sits behind a bubble.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_next  = RUN;
                if (bus_wait) begin
                    ex_mem_hold   = 1'b1;
                    state_next    = WAIT;
                    wait_cnt_next = CNT_W'(1);
                end
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase

        if (dispatch) begin
            if (ex_jump_en) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                take_jump   = 1'b1;
                state_next  = FLUSH;
            end else if (load_use) begin
                pc_hold     = 1'b1;
                if_id_hold  = 1'b1;
                id_ex_flush = 1'b1;
            end
        end

        // Controls read 0 while reset is asserted, whatever the inputs are doing.
        if (rst) begin
            pc_hold     = 1'b0;
            if_id_hold  = 1'b0;
            id_ex_hold  = 1'b0;
            ex_mem_hold = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            bus_err_o   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jump_en_o   <= 1'b0;
            jump_addr_o <= 32'd0;
        end else begin
            jump_en_o <= take_jump;
            if (take_jump) begin
                jump_addr_o <= ex_jump_addr;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= 32'd0;
            flush_cnt_o <= 32'd0;
        end else begin
            if (pc_hold) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (id_ex_flush) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard testbench for pipe_ctrl (WAIT_MAX=4): per-cycle expected control vectors are
// queued with each stimulus and compared at the following falling edge.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic        ex_is_load;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_wen;
    logic        ex_jump_en;
    logic [31:0] ex_jump_addr;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_hold;
    logic        if_id_hold;
    logic        id_ex_hold;
    logic        ex_mem_hold;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        bus_err_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    // Control vector bit order: pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
    // if_id_flush, id_ex_flush, jump_en_o, bus_err_o.
    localparam logic [7:0] NONE    = 8'b0000_0000;
    localparam logic [7:0] HOLD4   = 8'b1111_0000;
    localparam logic [7:0] LU      = 8'b1100_0100;
    localparam logic [7:0] JMP_T   = 8'b0000_1100;
    localparam logic [7:0] FLUSH_C = 8'b0000_1110;
    localparam logic [7:0] FL_WAIT = 8'b0001_1110;
    localparam logic [7:0] ERR     = 8'b0000_0001;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [31:0] addr;
    } exp_t;

    exp_t scoreboard[$];
    int   tests = 0;
    int   fails = 0;

    pipe_ctrl #(.WAIT_MAX(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr), .ex_reg_wen(ex_reg_wen),
        .ex_jump_en(ex_jump_en), .ex_jump_addr(ex_jump_addr),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_hold(id_ex_hold),
        .ex_mem_hold(ex_mem_hold), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o), .bus_err_o(bus_err_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic idleInputs();
        id_rs1_addr  = 5'd0;
        id_rs2_addr  = 5'd0;
        id_rs1_used  = 1'b0;
        id_rs2_used  = 1'b0;
        ex_is_load   = 1'b0;
        ex_rd_addr   = 5'd0;
        ex_reg_wen   = 1'b0;
        ex_jump_en   = 1'b0;
        ex_jump_addr = 32'd0;
        mem_req      = 1'b0;
        mem_ready    = 1'b0;
    endtask

    task automatic setLoad(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2, input logic wen);
        ex_is_load  = 1'b1;
        ex_reg_wen  = wen;
        ex_rd_addr  = rd;
        id_rs1_addr = rs1;
        id_rs1_used = u1;
        id_rs2_addr = rs2;
        id_rs2_used = u2;
    endtask

    task automatic setJump(input logic [31:0] target);
        ex_jump_en   = 1'b1;
        ex_jump_addr = target;
    endtask

    // Inputs are already driven; queue the expectation, compare at the falling edge,
    // then step to just after the next rising edge.
    task automatic applyStimulus(input string tag, input logic [7:0] ectrl, input logic [31:0] eaddr);
        exp_t e;
        logic [7:0] ctrl;
        scoreboard.push_back({ectrl, eaddr});
        @(negedge clk);
        e = scoreboard.pop_front();
        ctrl = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
                if_id_flush, id_ex_flush, jump_en_o, bus_err_o};
        checkOutput({tag, ".ctrl"}, {56'd0, ctrl}, {56'd0, e.ctrl});
        checkOutput({tag, ".addr"}, {32'd0, jump_addr_o}, {32'd0, e.addr});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
        applyStimulus("reset", NONE, 32'd0);
        checkOutput("reset.stall_cnt", {32'd0, stall_cnt_o}, 64'd0);
        checkOutput("reset.flush_cnt", {32'd0, flush_cnt_o}, 64'd0);
        rst = 1'b0;
        applyStimulus("idle", NONE, 32'd0);

        setLoad(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
        applyStimulus("lu_rs1", LU, 32'd0);
        idleInputs();
        applyStimulus("lu_after", NONE, 32'd0);
        setLoad(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1);
        applyStimulus("lu_x0", NONE, 32'd0);
        setLoad(5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1);
        applyStimulus("lu_rs2", LU, 32'd0);
        setLoad(5'd7, 5'd7, 1'b0, 5'd2, 1'b1, 1'b1);
        applyStimulus("lu_unused", NONE, 32'd0);
        setLoad(5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        applyStimulus("lu_nowen", NONE, 32'd0);

        idleInputs();
        setJump(32'h0000_0100);
        applyStimulus("jump_t", JMP_T, 32'd0);
        idleInputs();
        setJump(32'h0000_0999);
        setLoad(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
        applyStimulus("jump_t1", FLUSH_C, 32'h0000_0100);
        idleInputs();
        applyStimulus("jump_t2", NONE, 32'h0000_0100);

        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("bus_wait", HOLD4, 32'h0000_0100);
        mem_ready = 1'b1;
        applyStimulus("bus_release", NONE, 32'h0000_0100);
        idleInputs();
        applyStimulus("bus_after", NONE, 32'h0000_0100);

        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus("timeout_wait", HOLD4, 32'h0000_0100);
        applyStimulus("timeout_err", ERR, 32'h0000_0100);
        idleInputs();
        applyStimulus("timeout_after", NONE, 32'h0000_0100);

        mem_req = 1'b1;
        setJump(32'h0000_0200);
        setLoad(5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1);
        applyStimulus("prio_wait0", HOLD4, 32'h0000_0100);
        applyStimulus("prio_wait1", HOLD4, 32'h0000_0100);
        mem_ready = 1'b1;
        applyStimulus("prio_release", JMP_T, 32'h0000_0100);
        idleInputs();
        applyStimulus("prio_flush", FLUSH_C, 32'h0000_0200);

        setJump(32'h0000_0300);
        applyStimulus("fw_jump", JMP_T, 32'h0000_0200);
        idleInputs();
        mem_req = 1'b1;
        applyStimulus("fw_flush", FL_WAIT, 32'h0000_0300);
        applyStimulus("fw_wait", HOLD4, 32'h0000_0300);
        mem_ready = 1'b1;
        applyStimulus("fw_release", NONE, 32'h0000_0300);

        idleInputs();
        setJump(32'h0000_0400);
        applyStimulus("rst_jump", JMP_T, 32'h0000_0300);
        idleInputs();
        rst = 1'b1;
        applyStimulus("rst_in_flush", NONE, 32'd0);
        checkOutput("rst_in_flush.stall_cnt", {32'd0, stall_cnt_o}, 64'd0);
        checkOutput("rst_in_flush.flush_cnt", {32'd0, flush_cnt_o}, 64'd0);
        rst = 1'b0;
        applyStimulus("rst_run", NONE, 32'd0);

        setLoad(5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1);
        applyStimulus("perf_lu0", LU, 32'd0);
        idleInputs();
        applyStimulus("perf_idle0", NONE, 32'd0);
        setLoad(5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        applyStimulus("perf_lu1", LU, 32'd0);
        idleInputs();
        setJump(32'h0000_0500);
        applyStimulus("perf_jump", JMP_T, 32'd0);
        idleInputs();
        applyStimulus("perf_flush", FLUSH_C, 32'h0000_0500);
        applyStimulus("perf_idle1", NONE, 32'h0000_0500);
`ifdef PIPE_CTRL_PERF_EN
        checkOutput("perf.stall_cnt", {32'd0, stall_cnt_o}, 64'd2);
        checkOutput("perf.flush_cnt", {32'd0, flush_cnt_o}, 64'd4);
`else
        checkOutput("perf.stall_cnt", {32'd0, stall_cnt_o}, 64'd0);
        checkOutput("perf.flush_cnt", {32'd0, flush_cnt_o}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush controller for the RV32I 5-stage core. Watches the ID and EX stages for load-use hazards, taken jumps/branches and data-bus wait states, and drives hold/flush controls for the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers. It also issues a registered PC redirect. Sits beside the decode/execute datapath and is the only source of pipeline hold/flush.

## Interface
- WAIT_MAX, 255: bus-wait cycles tolerated before a forced release (1..2^CNT_W-1).
- CNT_W, 8: width of the wait counter.
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- id_rs1_addr / id_rs2_addr  in  5  source registers of the instruction in ID.
- id_rs1_used / id_rs2_used  in  1  the ID instruction reads rs1 / rs2.
- ex_is_load  in  1  the EX instruction is a load.
- ex_rd_addr  in  5  destination of the EX instruction.
- ex_reg_wen  in  1  the EX instruction writes rd.
- ex_jump_en  in  1  taken jump/branch resolved in EX.
- ex_jump_addr  in  32  jump target.
- mem_req  in  1  data-bus access in progress.
- mem_ready  in  1  data bus completes this cycle.
- pc_hold, if_id_hold, id_ex_hold, ex_mem_hold  out  1  the register keeps its value.
- if_id_flush, id_ex_flush  out  1  the register loads a NOP/zero bubble. Flush overrides hold.
- jump_en_o  out  1  registered PC redirect strobe.
- jump_addr_o  out  32  registered redirect target.
- bus_err_o  out  1  one-cycle pulse on wait timeout.
- stall_cnt_o, flush_cnt_o  out  32  performance counters.

## Operation
- States: RUN, FLUSH, WAIT. Reset value: state RUN, wait counter 0. All outputs read 0 during and after reset until the inputs change.
- Priority in RUN and FLUSH: bus wait > jump > load-use.
- Bus wait: `bus_wait = mem_req & ~mem_ready`.
  - In RUN, it asserts pc_hold, if_id_hold, id_ex_hold and ex_mem_hold. The state moves to WAIT and the counter is set to 1.
  - In WAIT, all four holds stay asserted while bus_wait persists, and the counter increments.
  - On mem_ready the holds drop that same cycle and the state returns to RUN.
  - If the counter equals WAIT_MAX while still waiting, bus_err_o pulses, the holds drop, the state returns to RUN and the counter clears.
- Jump: in RUN with ex_jump_en and no bus wait:
  - if_id_flush and id_ex_flush assert.
  - jump_en_o and jump_addr_o register ex_jump_addr at the edge, and the state moves to FLUSH.
- FLUSH, one cycle:
  - jump_en_o=1 and pc_hold=0, so the PC loads the target.
  - if_id_flush=1 squashes the stale fetch; id_ex_flush=1.
  - The next state is RUN. If bus_wait is true in FLUSH, ex_mem_hold=1 and the next state is WAIT.
  - A new ex_jump_en in FLUSH is ignored, because ID/EX holds a bubble.
- Load-use: in RUN with no bus wait and no jump, when ex_is_load & ex_reg_wen & ex_rd_addr≠0 and the rd matches a used rs:
  - pc_hold=1, if_id_hold=1, id_ex_flush=1 for one cycle. No state change.
  - x0 never creates a hazard.
- Reset mid-operation: an immediate return to RUN. Any pending redirect and the counter are discarded.

## Timing
- Holds, flushes and bus_err_o are combinational from the state, the counter and the current inputs. Pipeline registers sample them at the same edge.
- jump_en_o and jump_addr_o are registered.
- Taken-jump penalty: 2 bubbles. The PC holds the target at the end of cycle T+1 after EX resolution in cycle T.
- Load-use penalty: 1 bubble.
- Bus wait of N cycles: exactly N cycles of hold, released the cycle mem_ready=1. The maximum is WAIT_MAX cycles of hold before the forced release.
- jump_addr_o keeps its last value when jump_en_o=0.

## Configuration
- PIPE_CTRL_PERF_EN:
  - Defined: stall_cnt_o increments once per cycle with pc_hold=1. flush_cnt_o increments once per cycle with id_ex_flush=1. Both are 32-bit, wrap at 2^32 to 0, and reset to 0.
  - Undefined: no counter logic is built; both ports are constant 0.

## Test plan
- Load-use: EX is a load with rd=5, wen=1; ID rs1=5, used=1 → one cycle of pc_hold=1, if_id_hold=1, id_ex_flush=1. The same stimulus with rd=0 gives all controls 0.
- Jump: ex_jump_en=1, target 0x0000_0100 in cycle T → flushes in T. In T+1, jump_en_o=1, jump_addr_o=0x100, if_id_flush=1. RUN resumes in T+2.
- Bus wait: mem_req=1 with mem_ready low for 3 cycles, then high → four holds for 3 cycles, released in cycle 4, bus_err_o never asserted.
- Timeout: WAIT_MAX=4, mem_ready held low → bus_err_o pulses in the 4th wait cycle, holds drop, state RUN.
- Priority: bus wait, jump and load-use asserted together → only holds and WAIT. The jump is taken on the cycle mem_ready=1.
- Reset in FLUSH and with PIPE_CTRL_PERF_EN: assert rst during FLUSH → all outputs 0, state RUN. After 2 load-use stalls and 1 jump, stall_cnt_o=2 and flush_cnt_o=4.
